fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  RV64I instruction-fetch stage plus IF/ID pipeline register. Produces the instruction/address inputs consumed by decode.
//  Holds the PC and runs an instruction-memory req/ready + valid handshake. Handles decode stalls, branch/jump redirects and flushes.
//  Bubbles are injected as NOP (addi x0,x0,0).
// PARAMETERS
//  RESET_PC   64'h0   PC value loaded on reset
//  XLEN       64      address width
// PORTS
//  clock                     in   1     single clock, rising edge
//  reset_n                   in   1     asynchronous, active-low reset
//  stall                     in   1     decode cannot accept; hold IF/ID and PC
//  flush_decode              in   1     replace IF/ID contents with NOP next edge
//  pc_src                    in   1     redirect: take pc_target (branch/jump resolved)
//  pc_target                 in   XLEN  redirect address; bits [1:0] ignored (forced 0)
//  imem_req                  out  1     request valid (combinational from state)
//  imem_addr                 out  XLEN  request address = pc
//  imem_ready                in   1     memory accepts request this cycle
//  imem_valid                in   1     response data valid (>=1 cycle after accept)
//  imem_rdata                in   32    instruction word
//  current_instruction       out  32    IF/ID instruction
//  addr_current_instruction  out  XLEN  IF/ID PC of instruction
//  addr_next_instruction     out  XLEN  IF/ID PC+4
//  instr_valid               out  1     IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async, reset_n=0): pc=RESET_PC, state=REQ, current_instruction=32'h00000013,
//   addr_current_instruction=0, addr_next_instruction=0, instr_valid=0. imem_req=0 while reset_n=0.
//  FSM: REQ, WAIT, HOLD, DROP.
//  REQ: imem_req=1, imem_addr=pc. On imem_ready go WAIT.
//  WAIT: on imem_valid and !stall, load IF/ID={rdata,pc,pc+4,valid=1}, pc<=pc+4, go REQ.
//   On imem_valid and stall, capture rdata in hold buffer, go HOLD.
//  HOLD: imem_req=0. When !stall, load IF/ID from buffer, pc<=pc+4, go REQ.
//  DROP: waits for the stale response. On imem_valid, discard it and go REQ. imem_req=0.
//  Redirect (pc_src=1) overrides all of the above; pc<=pc_target & ~3:
//   REQ with imem_ready=1 -> DROP. REQ with imem_ready=0 -> REQ.
//   WAIT with imem_valid=1 -> discard data, go REQ. WAIT with imem_valid=0 -> DROP.
//   HOLD -> discard buffer, go REQ.
//   DROP -> stay DROP.
//   The redirect never loads a fetched word into IF/ID in that cycle.
//  IF/ID update priority, each edge:
//   1. flush_decode: load NOP, valid=0, addr_current=addr_next=0. Wins over stall.
//   2. stall: hold all IF/ID outputs.
//   3. a new instruction is delivered (WAIT+valid or HOLD release, with no pc_src): load it.
//   4. otherwise: load bubble (NOP, valid=0, addresses 0).
//  Stall must never duplicate an instruction; no-new-word cycles always bubble.
//  PC arithmetic is modulo 2^XLEN; pc+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0 with no flag.
//  Throughput: 1 instruction / 2 cycles with zero-wait memory (ready same cycle, valid next).
//   Only one outstanding request at a time.
//  Reset mid-transaction: state returns to REQ. A response arriving after reset_n rises while in REQ is ignored.
//   Memory is reset by the same reset_n.
// STRUCTURE
//  Shared package riscv_pkg holds: XLEN, NOP_INSTR=32'h00000013, fetch_state_t enum {REQ,WAIT,HOLD,DROP}.
//  One sub-module: if_id_register, containing the IF/ID flops with flush/stall/load/bubble priority.
//  The FSM, PC and hold buffer stay in fetch_stage.
// TESTING
//  1. Reset, zero-wait memory returning addr-tagged words -> IF/ID shows PCs 0,4,8 on alternate cycles.
//     Bubble cycles between them carry instr_valid=0 and 0x13.
//  2. stall=1 for 3 cycles while WAIT gets valid -> IF/ID frozen. Word appears once on the first !stall edge and is never duplicated.
//  3. pc_src=1, target 0x1003, during WAIT with a delayed response -> pc=0x1000, old response dropped.
//     Next imem_addr=0x1000; IF/ID never shows the dropped word.
//  4. flush_decode=1 together with stall=1 -> IF/ID=NOP, valid=0 on the next edge.
//  5. pc=64'hFFFF_FFFF_FFFF_FFFC fetch -> addr_next_instruction=0, next imem_addr=0.
//  6. Assert reset_n=0 in WAIT, release -> outputs at reset values, imem_req=1 at RESET_PC on the first cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64I front end: address width, the canonical
// NOP used for pipeline bubbles, and the fetch controller state encoding.
package riscv_pkg;

    localparam int XLEN = 64;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Each edge applies, in priority order:
// flush (NOP bubble), stall (hold), load of a newly delivered word, bubble.
module if_id_register #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_next_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            valid_o
);
    import riscv_pkg::*;

    logic [31:0]     instr_q,   instr_d;
    logic [XLEN-1:0] pc_q,      pc_d;
    logic [XLEN-1:0] pc_next_q, pc_next_d;
    logic            valid_q,   valid_d;

    // Resolve the update priority; anything that is not a stall or a real
    // delivery turns into a bubble so a word can never appear twice.
    always_comb begin
        instr_d   = NOP_INSTR;
        pc_d      = '0;
        pc_next_d = '0;
        valid_d   = 1'b0;
        if (flush_i) begin
            instr_d   = NOP_INSTR;
            pc_d      = '0;
            pc_next_d = '0;
            valid_d   = 1'b0;
        end else if (stall_i) begin
            instr_d   = instr_q;
            pc_d      = pc_q;
            pc_next_d = pc_next_q;
            valid_d   = valid_q;
        end else if (load_i) begin
            instr_d   = instr_i;
            pc_d      = pc_i;
            pc_next_d = pc_next_i;
            valid_d   = 1'b1;
        end
    end

    // IF/ID flops; reset presents a bubble to decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pc_next_o = pc_next_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV64I instruction fetch: PC, single-outstanding instruction-memory
// handshake, stall hold buffer and redirect handling, feeding IF/ID.
module fetch_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            flush_decode,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     current_instruction,
    output logic [XLEN-1:0] addr_current_instruction,
    output logic [XLEN-1:0] addr_next_instruction,
    output logic            instr_valid
);
    import riscv_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     hold_q, hold_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;
    logic            req_state;
    logic            deliver;
    logic [31:0]     deliver_word;

    assign pc_plus4       = pc_q + XLEN'(4);
    assign target_aligned = {pc_target[XLEN-1:2], 2'b00};

    // Next state, next PC and delivery decision; a redirect always wins and
    // never hands a fetched word to IF/ID in the same cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        req_state    = 1'b0;
        deliver      = 1'b0;
        deliver_word = imem_rdata;
        case (state_q)
            REQ: begin
                req_state = 1'b1;
                if (pc_src) begin
                    pc_d = target_aligned;
                    if (imem_ready) state_d = DROP;
                end else if (imem_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pc_src) begin
                    pc_d    = target_aligned;
                    state_d = imem_valid ? REQ : DROP;
                end else if (imem_valid) begin
                    if (!stall) begin
                        deliver = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                deliver_word = hold_q;
                if (pc_src) begin
                    pc_d    = target_aligned;
                    state_d = REQ;
                end else if (!stall) begin
                    deliver = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = REQ;
                end
            end
            DROP: begin
                // A further redirect only retargets the PC; a response in the
                // same cycle still retires the stale request.
                if (pc_src) pc_d = target_aligned;
                if (imem_valid) state_d = REQ;
            end
            default: state_d = REQ;
        endcase
    end

    // Controller state and PC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Hold buffer carries data only; its contents matter only in HOLD.
    always_ff @(posedge clock) begin
        hold_q <= hold_d;
    end

    assign imem_req  = req_state & reset_n;
    assign imem_addr = pc_q;

    if_id_register #(
        .XLEN (XLEN)
    ) u_if_id (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush_i   (flush_decode),
        .stall_i   (stall),
        .load_i    (deliver),
        .instr_i   (deliver_word),
        .pc_i      (pc_q),
        .pc_next_i (pc_plus4),
        .instr_o   (current_instruction),
        .pc_o      (addr_current_instruction),
        .pc_next_o (addr_next_instruction),
        .valid_o   (instr_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, reset-in-flight sequence,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall, flush_decode, pc_src;
    logic [63:0] pc_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready, imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] current_instruction;
    logic [63:0] addr_current_instruction, addr_next_instruction;
    logic        instr_valid;

    fetch_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .stall                    (stall),
        .flush_decode             (flush_decode),
        .pc_src                   (pc_src),
        .pc_target                (pc_target),
        .imem_req                 (imem_req),
        .imem_addr                (imem_addr),
        .imem_ready               (imem_ready),
        .imem_valid               (imem_valid),
        .imem_rdata               (imem_rdata),
        .current_instruction      (current_instruction),
        .addr_current_instruction (addr_current_instruction),
        .addr_next_instruction    (addr_next_instruction),
        .instr_valid              (instr_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          st, fl, ps;
        logic [63:0] tg;
        bit          rdy, vl;
        logic [31:0] rd;
        bit          ereq;
        logic [63:0] eaddr;
        logic [31:0] ein;
        bit          ev;
        logic [63:0] ecur, enext;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state (transaction level)
    logic [63:0] m_pc;
    bit          m_inflight, m_stale, m_held;
    logic [31:0] m_hword;
    logic [31:0] e_instr;
    bit          e_vld;
    logic [63:0] e_cur, e_next;

    // Memory model state
    bit          mem_busy;
    int          mem_cnt;
    logic [63:0] mem_addr;

    function automatic logic [31:0] tagw(input logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input bit st, fl, ps, input logic [63:0] tg, input bit rdy, vl,
                        input logic [31:0] rd, input bit ereq, input logic [63:0] eaddr,
                        input logic [31:0] ein, input bit ev, input logic [63:0] ecur, enext);
        vec_t v;
        v.st = st; v.fl = fl; v.ps = ps; v.tg = tg; v.rdy = rdy; v.vl = vl; v.rd = rd;
        v.ereq = ereq; v.eaddr = eaddr; v.ein = ein; v.ev = ev; v.ecur = ecur; v.enext = enext;
        vt.push_back(v);
    endtask

    task automatic model_step(input bit st, fl, ps, input logic [63:0] tg, input bit rdy, vl,
                              input logic [31:0] rd);
        bit          newv;
        logic [31:0] nw;
        logic [63:0] naddr;
        logic [63:0] tga;
        newv = 0; nw = '0; naddr = '0;
        tga  = tg & ~64'h3;
        if (!m_inflight && !m_held) begin
            if (rdy) begin m_inflight = 1; m_stale = ps; end
            if (ps) m_pc = tga;
        end else if (m_held) begin
            if (ps) begin m_held = 0; m_pc = tga; end
            else if (!st) begin newv = 1; nw = m_hword; naddr = m_pc; m_pc = m_pc + 4; m_held = 0; end
        end else if (m_stale) begin
            if (vl) begin m_inflight = 0; m_stale = 0; end
            if (ps) m_pc = tga;
        end else begin
            if (ps) begin
                m_pc = tga;
                if (vl) m_inflight = 0; else m_stale = 1;
            end else if (vl) begin
                m_inflight = 0;
                if (!st) begin newv = 1; nw = rd; naddr = m_pc; m_pc = m_pc + 4; end
                else begin m_held = 1; m_hword = rd; end
            end
        end
        if (fl) begin
            e_instr = NOP; e_vld = 0; e_cur = '0; e_next = '0;
        end else if (st) begin
            // decode holds IF/ID
        end else if (newv) begin
            e_instr = nw; e_vld = 1; e_cur = naddr; e_next = naddr + 64'd4;
        end else begin
            e_instr = NOP; e_vld = 0; e_cur = '0; e_next = '0;
        end
    endtask

    task automatic drive_idle();
        stall = 0; flush_decode = 0; pc_src = 0; pc_target = '0;
        imem_ready = 0; imem_valid = 0; imem_rdata = '0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ein, input bit ev,
                              input logic [63:0] ecur, enext);
        chk({tag, ".instr"}, {32'h0, current_instruction}, {32'h0, ein});
        chk({tag, ".valid"}, {63'h0, instr_valid}, {63'h0, ev});
        chk({tag, ".cur"},   addr_current_instruction, ecur);
        chk({tag, ".next"},  addr_next_instruction, enext);
    endtask

    initial begin
        logic [63:0] tfc;
        logic [63:0] tg;
        tfc = 64'hFFFF_FFFF_FFFF_FFFC;

        // st fl ps tg      rdy vl rd            | req addr      | instr       v cur       next
        addv(0,0,0,0,        1,0,0,              1,64'h0,       NOP,0,0,0);
        addv(0,0,0,0,        0,1,tagw(0),        0,64'h0,       tagw(0),1,0,4);
        addv(0,0,0,0,        1,0,0,              1,64'h4,       NOP,0,0,0);
        addv(0,0,0,0,        0,1,tagw(4),        0,64'h4,       tagw(4),1,4,8);
        addv(0,0,0,0,        1,0,0,              1,64'h8,       NOP,0,0,0);
        addv(1,0,0,0,        0,1,tagw(8),        0,64'h8,       NOP,0,0,0);
        addv(1,0,0,0,        0,0,0,              0,64'h8,       NOP,0,0,0);
        addv(1,0,0,0,        0,0,0,              0,64'h8,       NOP,0,0,0);
        addv(0,0,0,0,        0,0,0,              0,64'h8,       tagw(8),1,8,12);
        addv(1,0,0,0,        0,0,0,              1,64'hC,       tagw(8),1,8,12);
        addv(0,0,0,0,        0,0,0,              1,64'hC,       NOP,0,0,0);
        addv(0,0,0,0,        1,0,0,              1,64'hC,       NOP,0,0,0);
        addv(0,0,1,64'h1003, 0,0,0,              0,64'hC,       NOP,0,0,0);
        addv(0,0,0,0,        0,1,tagw(64'hC),    0,64'h1000,    NOP,0,0,0);
        addv(0,0,0,0,        1,0,0,              1,64'h1000,    NOP,0,0,0);
        addv(0,0,0,0,        0,1,tagw(64'h1000), 0,64'h1000,    tagw(64'h1000),1,64'h1000,64'h1004);
        addv(1,1,0,0,        1,0,0,              1,64'h1004,    NOP,0,0,0);
        addv(0,0,0,0,        0,1,tagw(64'h1004), 0,64'h1004,    tagw(64'h1004),1,64'h1004,64'h1008);
        addv(0,0,1,tfc,      1,0,0,              1,64'h1008,    NOP,0,0,0);
        addv(0,0,0,0,        0,1,tagw(64'h1008), 0,tfc,         NOP,0,0,0);
        addv(0,0,0,0,        1,0,0,              1,tfc,         NOP,0,0,0);
        addv(0,0,0,0,        0,1,tagw(tfc),      0,tfc,         tagw(tfc),1,tfc,64'h0);
        addv(0,0,0,0,        0,0,0,              1,64'h0,       NOP,0,0,0);
        addv(0,0,0,0,        1,0,0,              1,64'h0,       NOP,0,0,0);
        addv(0,0,0,0,        0,1,tagw(0),        0,64'h0,       tagw(0),1,0,4);
        addv(1,0,0,0,        1,0,0,              1,64'h4,       tagw(0),1,0,4);

        // Reset state
        reset_n = 0;
        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        chk("rst.req", {63'h0, imem_req}, 64'h0);
        chk("rst.addr", imem_addr, 64'h0);
        check_ifid("rst", NOP, 0, 0, 0);
        @(negedge clock);
        reset_n = 1;

        // Directed table
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clock);
            stall = vt[i].st; flush_decode = vt[i].fl; pc_src = vt[i].ps; pc_target = vt[i].tg;
            imem_ready = vt[i].rdy; imem_valid = vt[i].vl; imem_rdata = vt[i].rd;
            #1;
            chk($sformatf("v%0d.req", i), {63'h0, imem_req}, {63'h0, vt[i].ereq});
            chk($sformatf("v%0d.addr", i), imem_addr, vt[i].eaddr);
            @(posedge clock);
            #1;
            check_ifid($sformatf("v%0d", i), vt[i].ein, vt[i].ev, vt[i].ecur, vt[i].enext);
        end

        // Reset asserted while a request is outstanding (state WAIT, pc=4)
        @(negedge clock);
        drive_idle();
        reset_n = 0;
        #1;
        chk("midrst.req", {63'h0, imem_req}, 64'h0);
        chk("midrst.addr", imem_addr, 64'h0);
        check_ifid("midrst", NOP, 0, 0, 0);
        @(negedge clock);
        reset_n = 1;
        #1;
        chk("postrst.req", {63'h0, imem_req}, 64'h1);
        chk("postrst.addr", imem_addr, 64'h0);
        check_ifid("postrst", NOP, 0, 0, 0);

        // Randomized traffic against the reference model
        @(negedge clock);
        reset_n = 0;
        drive_idle();
        m_pc = '0; m_inflight = 0; m_stale = 0; m_held = 0; m_hword = '0;
        e_instr = NOP; e_vld = 0; e_cur = '0; e_next = '0;
        mem_busy = 0; mem_cnt = 0; mem_addr = '0;
        #2;
        reset_n = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            check_ifid($sformatf("r%0d", c), e_instr, e_vld, e_cur, e_next);
            stall        = ($urandom_range(0, 3) == 0);
            flush_decode = ($urandom_range(0, 9) == 0);
            pc_src       = ($urandom_range(0, 7) == 0);
            tg = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) tg = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, tg[3:0]};
            pc_target    = tg;
            imem_ready   = $urandom_range(0, 1);
            imem_valid   = mem_busy && (mem_cnt == 0);
            imem_rdata   = imem_valid ? tagw(mem_addr) : $urandom;
            #1;
            chk($sformatf("r%0d.req", c), {63'h0, imem_req}, {63'h0, (!m_inflight && !m_held)});
            chk($sformatf("r%0d.addr", c), imem_addr, m_pc);
            model_step(stall, flush_decode, pc_src, pc_target, imem_ready, imem_valid, imem_rdata);
            if (imem_valid) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (imem_req && imem_ready) begin
                mem_busy = 1;
                mem_cnt  = $urandom_range(0, 2);
                mem_addr = imem_addr;
            end
            @(posedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
